// File: rtl/settle_pkg.sv
// Shared types for the settle engine: controller states and pass evaluation orders.
package settle_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      PARALLEL = 1'b0,
      ORDERED  = 1'b1
   } mode_t;

endpackage

// File: rtl/settle_step.sv
// One combinational evaluation pass over the channel chain, plus the no-change detect.
module settle_step
   import settle_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic [CHANNELS*WIDTH-1:0] cur,
   input  logic [CHANNELS-1:0]       cur_known,
   input  logic [WIDTH-1:0]          src,
   input  logic                      src_known,
   input  logic                      mode,
   output logic [CHANNELS*WIDTH-1:0] nxt,
   output logic [CHANNELS-1:0]       nxt_known,
   output logic                      stable
);

   // Build the next channel vector; unknown channels always carry a zero value.
   always_comb begin
      nxt       = '0;
      nxt_known = '0;
      nxt_known[0]     = src_known;
      nxt[0 +: WIDTH]  = src_known ? src : {WIDTH{1'b0}};
      for (int i = 1; i < CHANNELS; i++) begin
         if (mode_t'(mode) == ORDERED) begin
            nxt_known[i]            = nxt_known[i-1];
            nxt[i*WIDTH +: WIDTH]   = nxt[(i-1)*WIDTH +: WIDTH];
         end else begin
            nxt_known[i]            = cur_known[i-1];
            nxt[i*WIDTH +: WIDTH]   = cur_known[i-1] ? cur[(i-1)*WIDTH +: WIDTH]
                                                     : {WIDTH{1'b0}};
         end
      end
      stable = (nxt == cur) && (nxt_known == cur_known);
   end

endmodule

// File: rtl/settle_iter.sv
// Settle engine: iterates settle_step once per clock until a fixed point or the pass bound.
module settle_iter
   import settle_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int MAX_ITER = 16,
   localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [CHANNELS*WIDTH-1:0] init_val,
   input  logic [CHANNELS-1:0]       init_known,
   input  logic [WIDTH-1:0]          drive,
   input  logic                      mode,
   input  logic                      feedback,
   output logic                      busy,
   output logic                      done_valid,
   input  logic                      done_ready,
   output logic [CHANNELS*WIDTH-1:0] result_val,
   output logic [CHANNELS-1:0]       result_known,
   output logic [ITER_W-1:0]         iter_count,
   output logic                      converged
);

   state_t                    state_r;
   logic [CHANNELS*WIDTH-1:0] val_r;
   logic [CHANNELS-1:0]       known_r;
   logic [WIDTH-1:0]          drive_r;
   logic                      mode_r;
   logic                      feedback_r;
   logic [ITER_W-1:0]         iter_r;
   logic                      conv_r;
   logic                      busy_r;
   logic                      done_r;

   logic [CHANNELS*WIDTH-1:0] init_canon_s;
   logic [WIDTH-1:0]          src_s;
   logic                      src_known_s;
   logic [CHANNELS*WIDTH-1:0] nxt_s;
   logic [CHANNELS-1:0]       nxt_known_s;
   logic                      stable_s;
   logic                      bound_s;

   // Zero the value bits of unknown initial channels so comparisons see one encoding.
   always_comb begin
      init_canon_s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (init_known[i]) begin
            init_canon_s[i*WIDTH +: WIDTH] = init_val[i*WIDTH +: WIDTH];
         end else begin
            init_canon_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
         end
      end
   end

   // Chain source: external drive, or inverted tail when the feedback loop is closed.
   always_comb begin
      if (feedback_r) begin
         src_s       = ~val_r[(CHANNELS-1)*WIDTH +: WIDTH];
         src_known_s = known_r[CHANNELS-1];
      end else begin
         src_s       = drive_r;
         src_known_s = 1'b1;
      end
   end

   settle_step #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS)
   ) u_step (
      .cur       (val_r),
      .cur_known (known_r),
      .src       (src_s),
      .src_known (src_known_s),
      .mode      (mode_r),
      .nxt       (nxt_s),
      .nxt_known (nxt_known_s),
      .stable    (stable_s)
   );

   assign bound_s = ((iter_r + ITER_W'(1)) == ITER_W'(MAX_ITER));

   // Controller FSM with the channel registers, pass counter and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         val_r      <= '0;
         known_r    <= '0;
         drive_r    <= '0;
         mode_r     <= 1'b0;
         feedback_r <= 1'b0;
         iter_r     <= '0;
         conv_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_valid) begin
                  val_r      <= init_canon_s;
                  known_r    <= init_known;
                  drive_r    <= drive;
                  mode_r     <= mode;
                  feedback_r <= feedback;
                  iter_r     <= '0;
                  conv_r     <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= RUN;
               end
            end
            RUN: begin
               iter_r  <= iter_r + ITER_W'(1);
               val_r   <= nxt_s;
               known_r <= nxt_known_s;
               // A stable pass wins even when it is also the last allowed one.
               if (stable_s) begin
                  conv_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else if (bound_s) begin
                  conv_r  <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  done_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign start_ready  = (state_r == IDLE) && !rst;
   assign busy         = busy_r;
   assign done_valid   = done_r;
   assign result_val   = val_r;
   assign result_known = known_r;
   assign iter_count   = iter_r;
   assign converged    = conv_r;

endmodule

// File: tb/tb_settle_iter.sv
// Directed bench for settle_iter with an array-based pass model checked on every DONE cycle.
module tb_settle_iter;

   localparam int W    = 8;
   localparam int C    = 4;
   localparam int MAXI = 16;
   localparam int IW   = $clog2(MAXI + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            start_valid;
   logic            start_ready;
   logic [C*W-1:0]  init_val;
   logic [C-1:0]    init_known;
   logic [W-1:0]    drive;
   logic            mode;
   logic            feedback;
   logic            busy;
   logic            done_valid;
   logic            done_ready;
   logic [C*W-1:0]  result_val;
   logic [C-1:0]    result_known;
   logic [IW-1:0]   iter_count;
   logic            converged;

   int n_checks = 0;
   int n_fail   = 0;

   logic           armed = 1'b0;
   logic [C*W-1:0] exp_val;
   logic [C-1:0]   exp_known;
   int             exp_it;
   logic           exp_conv;

   settle_iter #(.WIDTH(W), .CHANNELS(C), .MAX_ITER(MAXI)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .init_val     (init_val),
      .init_known   (init_known),
      .drive        (drive),
      .mode         (mode),
      .feedback     (feedback),
      .busy         (busy),
      .done_valid   (done_valid),
      .done_ready   (done_ready),
      .result_val   (result_val),
      .result_known (result_known),
      .iter_count   (iter_count),
      .converged    (converged)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Channel-array model: apply the chain rules pass by pass until nothing changes.
   task automatic model(input logic [C*W-1:0] iv, input logic [C-1:0] ik, input logic [W-1:0] drv,
                        input logic md, input logic fb,
                        output logic [C*W-1:0] ov, output logic [C-1:0] ok,
                        output int oit, output logic oconv);
      logic [W-1:0] v[C];
      logic         k[C];
      logic [W-1:0] nv[C];
      logic         nk[C];
      logic [W-1:0] s;
      logic         sk;
      bit           same;
      for (int i = 0; i < C; i++) begin
         k[i] = ik[i];
         v[i] = ik[i] ? iv[i*W +: W] : 8'h00;
      end
      oit   = 0;
      oconv = 1'b0;
      for (int p = 1; p <= MAXI; p++) begin
         sk = fb ? k[C-1] : 1'b1;
         s  = !sk ? 8'h00 : (fb ? ~v[C-1] : drv);
         for (int i = 0; i < C; i++) begin
            if (md || i == 0) begin
               nv[i] = s;
               nk[i] = sk;
            end else begin
               nv[i] = v[i-1];
               nk[i] = k[i-1];
            end
         end
         same = 1;
         for (int i = 0; i < C; i++) if (nv[i] !== v[i] || nk[i] !== k[i]) same = 0;
         v   = nv;
         k   = nk;
         oit = p;
         if (same) begin
            oconv = 1'b1;
            break;
         end
      end
      for (int i = 0; i < C; i++) begin
         ov[i*W +: W] = v[i];
         ok[i]        = k[i];
      end
   endtask

   // Every DONE cycle of an armed run must match the model and stay put until accepted.
   always @(negedge clk) begin
      if (armed && done_valid) begin
         check("model_val",   result_val,   exp_val);
         check("model_known", result_known, exp_known);
         check("model_iter",  iter_count,   exp_it);
         check("model_conv",  converged,    exp_conv);
         check("done_not_busy", busy, 0);
      end
   end

   task automatic run(input logic [C*W-1:0] iv, input logic [C-1:0] ik, input logic [W-1:0] drv,
                      input logic md, input logic fb, input int lit_it, input logic lit_conv,
                      input int hold);
      int waitc;
      @(negedge clk);
      check("start_ready_idle", start_ready, 1);
      init_val    = iv;
      init_known  = ik;
      drive       = drv;
      mode        = md;
      feedback    = fb;
      start_valid = 1'b1;
      model(iv, ik, drv, md, fb, exp_val, exp_known, exp_it, exp_conv);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      check("busy_after_start", busy, 1);
      armed = 1'b1;
      waitc = 0;
      while (!done_valid && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check("done_seen", done_valid, 1);
      check("latency", waitc, lit_it + 1);
      check("lit_iter", iter_count, lit_it);
      check("lit_conv", converged, lit_conv);
      repeat (hold) @(negedge clk);
      check("done_held", done_valid, 1);
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      done_ready = 1'b0;
      armed      = 1'b0;
      check("idle_after_accept", done_valid, 0);
      check("result_kept_idle", result_val, exp_val);
   endtask

   initial begin : stim
      int waitc;
      rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
      init_val = '0; init_known = '0; drive = '0; mode = 1'b0; feedback = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_val",   result_val, 0);
      check("rst_known", result_known, 0);
      check("rst_iter",  iter_count, 0);
      check("rst_conv",  converged, 0);
      check("rst_done",  done_valid, 0);
      check("rst_busy",  busy, 0);
      check("rst_start_ready", start_ready, 0);
      @(negedge clk);
      rst = 1'b0;

      run(32'h0000_0000, 4'hF, 8'hA5, 1'b0, 1'b0, 5,  1'b1, 0);
      run(32'h0000_0000, 4'hF, 8'hA5, 1'b1, 1'b0, 2,  1'b1, 0);
      run(32'hA5A5_A5A5, 4'hF, 8'hA5, 1'b0, 1'b0, 1,  1'b1, 0);
      run(32'h1234_5678, 4'h0, 8'h01, 1'b0, 1'b0, 5,  1'b1, 0);
      check("unknown_cleared", result_known, 4'hF);
      check("unknown_vals", result_val, 32'h0101_0101);
      run(32'hDEAD_BEEF, 4'b0101, 8'h3C, 1'b0, 1'b0, 5, 1'b1, 0);
      run(32'h0000_0000, 4'hF, 8'h00, 1'b1, 1'b1, 16, 1'b0, 3);
      check("fb_final", result_val, 32'h0000_0000);

      // Reset in the middle of a PARALLEL run.
      @(negedge clk);
      init_val = '0; init_known = 4'hF; drive = 8'hA5; mode = 1'b0; feedback = 1'b0;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      waitc = 0;
      while (iter_count != 3 && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check("reached_pass3", iter_count, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_val",   result_val, 0);
      check("mid_rst_known", result_known, 0);
      check("mid_rst_iter",  iter_count, 0);
      check("mid_rst_conv",  converged, 0);
      check("mid_rst_busy",  busy, 0);
      check("mid_rst_done",  done_valid, 0);
      check("mid_rst_ready", start_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", start_ready, 1);
      run(32'h0000_0000, 4'hF, 8'hA5, 1'b0, 1'b0, 5, 1'b1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/settle_iter.md
# settle_iter

Parametrised fixed-point settle engine for the scheduling examples. It models a chain of `CHANNELS` dependent signals (`ch[0]` is driven by a source, and `ch[i]` copies `ch[i-1]`) evaluated one pass per clock until no channel changes. Two evaluation orders are selectable: parallel snapshot or in-order propagation. Known/unknown tracking, an optional inverting feedback loop and an iteration bound let the block report both convergence and non-convergence.

## Interface
- `WIDTH`, 8, bits per channel value (>=1)
- `CHANNELS`, 4, chain length (>=2)
- `MAX_ITER`, 16, pass bound before giving up (>=1)
- `ITER_W`, `$clog2(MAX_ITER+1)`, iteration counter width (derived, not overridden)

Ports (reset is synchronous and active-high):
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start_valid` in 1: request a settle run
- `start_ready` out 1: `(state==IDLE) && !rst`
- `init_val` in CHANNELS*WIDTH: initial channel values, ch i at `[i*WIDTH +: WIDTH]`
- `init_known` in CHANNELS: per-channel known flag (0 = x)
- `drive` in WIDTH: source value for `ch[0]`
- `mode` in 1: 0 = PARALLEL, 1 = ORDERED
- `feedback` in 1: 1 = `ch[0]` source is `~ch[CHANNELS-1]` instead of `drive`
- `busy` out 1: high in RUN
- `done_valid` out 1: result available (DONE state)
- `done_ready` in 1: consumer accepts result
- `result_val` out CHANNELS*WIDTH: current/final channel values
- `result_known` out CHANNELS: current/final known flags
- `iter_count` out ITER_W: passes performed
- `converged` out 1: 1 = fixed point reached, 0 = bound hit

## Operation
- States: IDLE -> RUN on start handshake; RUN -> DONE on stable pass or bound; DONE -> IDLE on `done_valid && done_ready`.
- On start: latch `init_val`/`init_known` into channel regs, latch `drive`/`mode`/`feedback`, clear `iter_count` and `converged`. Value bits of unknown channels are canonicalised to 0.
- Source: `src = feedback ? ~cur[N-1] : drive`; `src_known = feedback ? cur_known[N-1] : 1`.
- PARALLEL pass: `nxt[0]=src`, `nxt[i]=cur[i-1]`, all from the pre-pass snapshot.
- ORDERED pass: `nxt[0]=src`, `nxt[i]=nxt[i-1]`, propagated within the pass. `src` still uses the pre-pass `cur[N-1]`.
- Known flags propagate identically. An unknown channel's value is 0.
- Each pass: `iter_count <= iter_count+1`; channels <= nxt.
  - Stable (nxt==cur for all values and known flags): `converged<=1`, go to DONE.
  - Else if `iter_count+1 == MAX_ITER`: `converged<=0`, go to DONE.
  - Stable takes priority over the bound on the same pass.
- The confirming (no-change) pass counts in `iter_count`.
- DONE holds all outputs stable until accepted. `start_valid` is ignored outside IDLE.
- The result outputs keep their last values in IDLE until the next start.

## Timing
- Start handshake at edge E0; pass k commits at edge Ek; `done_valid` is high in the cycle after the final pass edge.
- Total latency from start to `done_valid` is `iter_count` cycles plus 1 (the state entry).
- Back-to-back: a new start may be accepted the cycle after the done handshake, when IDLE is entered.
- Reset (any state, including mid-RUN or DONE) returns to IDLE at the next edge. Reset values:
  - `result_val=0`, `result_known=0`, `iter_count=0`, `converged=0`
  - `done_valid=0`, `busy=0`; `start_ready=0` while `rst` is high
- No counter wrap: `ITER_W` holds `MAX_ITER`, and RUN exits at the bound.

## Structure
- Package `settle_pkg`: `state_t` enum {IDLE, RUN, DONE}; `mode_t` enum {PARALLEL, ORDERED}.
- Sub-module `settle_step`: purely combinational next-pass function (cur, known, src, mode -> nxt, nxt_known, stable). Parametrised by WIDTH and CHANNELS.
- Top `settle_iter` contains the FSM, registers, counter and handshakes.

## Test plan
- Defaults, PARALLEL, init all known 0, drive=8'hA5 -> `converged=1`, `iter_count=5`, all channels A5 and known.
- Same inputs in ORDERED -> `converged=1`, `iter_count=2`, all channels A5.
- PARALLEL, init all 8'hA5 known, drive=8'hA5 -> `converged=1`, `iter_count=1`.
- PARALLEL, `init_known=4'b0000`, drive=8'h01 -> unknowns clear one channel per pass; `iter_count=5`; `result_known=4'hF`.
- `feedback=1`, ORDERED, init known 0 -> toggles every pass; `converged=0`, `iter_count=16`. Hold `done_ready=0` for 3 cycles -> outputs stable.
- Assert `rst` at pass 3 of a PARALLEL run -> IDLE next edge with all reset values. A fresh start then yields `iter_count=5`.
